// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM state encoding and the default reset fetch address.
// No logic: pure declarations imported by the fetch RTL files.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory read bus between the fetch controller and imem.
// Latency: none, wires only.
// Backpressure: a read completes only in a cycle with both req and ack high.
interface fetch_ctrl_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl_add4.sv
// Sequential-pc incrementer: the address of the next word.
// Latency: combinational.
// Backpressure: none; 32-bit wrap from 0xFFFF_FFFC to 0 is intended.
module F_add4 (
  input  logic [31:0] i_a,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + 32'd4;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: reads imem at pc, buffers one word for decode.
// Latency: first request one cycle after reset release; word visible the cycle after its ack.
// Backpressure: a held (stalled) buffer blocks new requests; redirects flush and retarget.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  fetch_ctrl_if.master imem,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_flush,
  output logic        o_fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_inc;
  logic         r_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_opc;
  logic         r_flush;
  logic         r_fault;
  logic         w_req;
  logic         w_xfer;
  logic         w_redir_ok;
  logic         w_redir_bad;

  F_add4 u_add4 (
    .i_a   (r_pc),
    .o_sum (w_pc_inc)
  );

  // State register; reset always restarts in IDLE.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, request and redirect classification; a redirect suppresses the request.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_xfer      = 1'b0;
    w_redir_ok  = 1'b0;
    w_redir_bad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_redirect) begin
          if (i_redirect_addr[1:0] == 2'b00) begin
            w_redir_ok = 1'b1;
          end else begin
            w_redir_bad = 1'b1;
            w_state_nxt = ST_FAULT;
          end
        end else begin
          w_req  = ~r_valid | ~i_stall;
          w_xfer = w_req & imem.i_imem_ack;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // pc, output buffer, flush pulse and sticky fault; redirect outranks transfer and stall.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_opc   <= 32'h0;
      r_flush <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_flush <= w_redir_ok | w_redir_bad;
      if (w_redir_ok) begin
        r_pc    <= i_redirect_addr;
        r_valid <= 1'b0;
      end else if (w_redir_bad) begin
        r_fault <= 1'b1;
        r_valid <= 1'b0;
      end else if (w_xfer) begin
        r_instr <= imem.i_imem_rdata;
        r_opc   <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= w_pc_inc;
      end else if ((r_state != ST_RUN) || !i_stall) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign imem.o_imem_req  = w_req;
  assign imem.o_imem_addr = r_pc;
  assign o_valid          = r_valid;
  assign o_instr          = r_instr;
  assign o_pc             = r_opc;
  assign o_flush          = r_flush;
  assign o_fault          = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl against a cycle-level reference model.
// Directed scenarios (sequential fetch, stall, redirect, wrap, ack gaps, fault, reset) plus random traffic.
// Every output is compared each cycle on the falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        stall;
  logic        redir;
  logic [31:0] raddr;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_flush;
  logic        o_fault;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_stall         (stall),
    .i_redirect      (redir),
    .i_redirect_addr (raddr),
    .imem            (imem_bus),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .o_flush         (o_flush),
    .o_fault         (o_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = waiting after reset, 1 = fetching, 2 = faulted.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic        m_flush;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_req();
    return (m_mode == 1) && !redir && (!m_valid || !stall);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_opc   = 32'h0;
    m_flush = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_step();
    logic want;
    want = model_req();
    if (m_mode == 0) begin
      m_mode  = 1;
      m_flush = 1'b0;
    end else if (m_mode == 1) begin
      if (redir) begin
        m_flush = 1'b1;
        m_valid = 1'b0;
        if (raddr[1:0] == 2'b00) begin
          m_pc = raddr;
        end else begin
          m_mode  = 2;
          m_fault = 1'b1;
        end
      end else begin
        m_flush = 1'b0;
        if (want && imem_bus.i_imem_ack) begin
          m_instr = imem_bus.i_imem_rdata;
          m_opc   = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end else if (!stall) begin
          m_valid = 1'b0;
        end
      end
    end else begin
      m_flush = 1'b0;
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("imem_req",  {31'h0, imem_bus.o_imem_req}, {31'h0, model_req()});
    chk("imem_addr", imem_bus.o_imem_addr, m_pc);
    chk("valid",     {31'h0, o_valid}, {31'h0, m_valid});
    chk("instr",     o_instr, m_instr);
    chk("pc",        o_pc, m_opc);
    chk("flush",     {31'h0, o_flush}, {31'h0, m_flush});
    chk("fault",     {31'h0, o_fault}, {31'h0, m_fault});
  endtask

  task automatic cyc(input logic s, input logic r, input logic [31:0] a,
                     input logic k, input logic [31:0] d);
    stall                 = s;
    redir                 = r;
    raddr                 = a;
    imem_bus.i_imem_ack   = k;
    imem_bus.i_imem_rdata = d;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (nrst) model_step();
    #1;
  endtask

  task automatic rnd_cyc(input int redir_odds);
    cyc($urandom_range(0, 3) == 0, $urandom_range(0, redir_odds) == 0,
        $urandom & 32'h0000_FFFC, $urandom_range(0, 3) != 0, $urandom);
  endtask

  // Reset asserted while an ack is being presented; the ack must be lost.
  task automatic reset_mid_xfer();
    stall                 = 1'b0;
    redir                 = 1'b0;
    imem_bus.i_imem_ack   = 1'b1;
    imem_bus.i_imem_rdata = $urandom;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #2 nrst = 1'b1;
  endtask

  initial begin
    nrst                  = 1'b0;
    stall                 = 1'b0;
    redir                 = 1'b0;
    raddr                 = 32'h0;
    imem_bus.i_imem_ack   = 1'b0;
    imem_bus.i_imem_rdata = 32'h0;
    model_reset();
    #12 check_all();
    @(posedge clk);
    #2 nrst = 1'b1;

    // Sequential fetch with ack always high.
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    // Stall while holding a word, then release.
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    // Redirect coinciding with an ack, then back-to-back redirects.
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b1, $urandom);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, $urandom);
    cyc(1'b0, 1'b1, 32'h0000_0300, 1'b1, $urandom);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1, $urandom);

    // Random traffic with occasional aligned redirects.
    repeat (400) rnd_cyc(15);

    // Address wrap at the top of the space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
    chk("wrap_addr", imem_bus.o_imem_addr, 32'h0000_0000);
    chk("wrap_opc", o_pc, 32'hFFFF_FFFC);

    // Ack held low: request stays up, address stable, buffer drains.
    repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b0, $urandom);

    // Reset during a transfer restarts fetch at the reset address.
    reset_mid_xfer();
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1, $urandom);

    // Misaligned redirect faults; everything after is ignored.
    cyc(1'b0, 1'b1, 32'h0000_0102, 1'b1, $urandom);
    repeat (20) rnd_cyc(2);

    // Reset clears the fault and fetch resumes.
    reset_mid_xfer();
    repeat (100) rnd_cyc(15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
